dvp_capture_ctrl: RTL and testbench

//  Frame-level sequencer after dvp_receiver, before byte_aligner_rgb565.

---
 rtl/dvp_pkg.sv | 15 +
 rtl/dvp_vsync_sync.sv | 29 ++
 rtl/dvp_capture_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dvp_capture_ctrl.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared types and default widths for the DVP capture controller slice.
package dvp_pkg;

    localparam int DVP_DATA_W     = 8;
    localparam int DVP_LINE_CNT_W = 11;
    localparam int DVP_BYTE_CNT_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        SKIP    = 2'd3
    } state_e;

endpackage

// File: rtl/dvp_vsync_sync.sv
// Two-flop synchroniser for raw DVP vsync plus one-cycle rise/fall strobes.
module dvp_vsync_sync (
    input  logic pclk,
    input  logic rst,
    input  logic vsync,
    output logic vs_rise,
    output logic vs_fall
);

    logic vs_meta;
    logic vs_sync;
    logic vs_prev;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign vs_rise = vs_sync & ~vs_prev;
    assign vs_fall = ~vs_sync & vs_prev;

endmodule

// File: rtl/dvp_capture_ctrl.sv
// Frame sequencer between dvp_receiver and the RGB565 byte aligner.
// Define DVP_CTRL_LINE_CHECK_EN to enable the line/frame length checks.
module dvp_capture_ctrl
    import dvp_pkg::*;
#(
    parameter int DATA_W             = DVP_DATA_W,
    parameter int LINE_CNT_W         = DVP_LINE_CNT_W,
    parameter int BYTE_CNT_W         = DVP_BYTE_CNT_W,
    parameter int EXP_BYTES_PER_LINE = 1280,
    parameter int EXP_LINES          = 480
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  vsync,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic [DATA_W-1:0]     m_tdata,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [3:0]            frame_skip,
    output logic                  busy,
    output logic                  frame_done,
    output logic [LINE_CNT_W-1:0] frame_lines,
    output logic [BYTE_CNT_W-1:0] line_bytes,
    output logic                  overflow,
    output logic                  err_line_len,
    output logic                  err_frame_len
);

    logic                  vs_rise;
    logic                  vs_fall;
    state_e                state;
    logic                  cont_r;
    logic                  stop_pend;
    logic                  first_pend;
    logic [3:0]            skip_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [BYTE_CNT_W-1:0] byte_inc;
    logic [LINE_CNT_W-1:0] line_cnt;
    logic [LINE_CNT_W-1:0] line_inc;
    logic [LINE_CNT_W-1:0] lines_at_end;
    logic                  beat;
    logic                  line_end;
    logic                  load;
    logic                  arm_req;

    dvp_vsync_sync u_vsync (
        .pclk    (pclk),
        .rst     (rst),
        .vsync   (vsync),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall)
    );

    assign beat         = (state == CAPTURE) && s_tvalid;
    assign line_end     = beat && s_tlast;
    assign byte_inc     = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;
    assign line_inc     = (&line_cnt) ? line_cnt : line_cnt + 1'b1;
    assign lines_at_end = line_end ? line_inc : line_cnt;
    assign load         = !m_tvalid || m_tready;
    assign arm_req      = start && (state == IDLE);
    assign busy         = (state != IDLE);

    // Skip counter is cleared on start so the first frame after arming is always captured.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            cont_r     <= 1'b0;
            stop_pend  <= 1'b0;
            first_pend <= 1'b0;
            skip_cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ARM;
                        cont_r    <= continuous;
                        stop_pend <= 1'b0;
                        skip_cnt  <= 4'd0;
                    end
                end
                ARM: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (vs_fall) begin
                        if (skip_cnt == 4'd0) begin
                            state      <= CAPTURE;
                            skip_cnt   <= frame_skip;
                            first_pend <= 1'b1;
                        end else begin
                            state    <= SKIP;
                            skip_cnt <= skip_cnt - 1'b1;
                        end
                    end
                end
                CAPTURE, SKIP: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (vs_rise) begin
                        state <= (cont_r && !stop_pend && !stop) ? ARM : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (beat && load) begin
                first_pend <= 1'b0;
            end
        end
    end

    // A beat arriving while the output register is stalled is dropped, never queued.
    always_ff @(posedge pclk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (beat) begin
                if (load) begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= s_tdata;
                    m_tlast  <= s_tlast;
                    m_tuser  <= first_pend;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (arm_req) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            byte_cnt    <= '0;
            line_cnt    <= '0;
            line_bytes  <= '0;
            frame_lines <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (line_end) begin
                line_bytes <= byte_inc;
                byte_cnt   <= '0;
                line_cnt   <= line_inc;
            end else if (beat) begin
                byte_cnt <= byte_inc;
            end
            if (vs_rise) begin
                byte_cnt <= '0;
                line_cnt <= '0;
                if (state == CAPTURE) begin
                    frame_done  <= 1'b1;
                    frame_lines <= lines_at_end;
                end
            end
        end
    end

`ifdef DVP_CTRL_LINE_CHECK_EN
    logic [LINE_CNT_W-1:0] lines_with_partial;
    logic                  partial_line;

    // The frame check counts a trailing line that never saw tlast.
    assign partial_line       = !line_end && ((byte_cnt != '0) || beat);
    assign lines_with_partial = (partial_line && !(&line_cnt)) ? line_cnt + 1'b1 : lines_at_end;

    always_ff @(posedge pclk) begin
        if (rst) begin
            err_line_len  <= 1'b0;
            err_frame_len <= 1'b0;
        end else if (arm_req) begin
            err_line_len  <= 1'b0;
            err_frame_len <= 1'b0;
        end else begin
            if (line_end && (byte_inc != BYTE_CNT_W'(EXP_BYTES_PER_LINE))) begin
                err_line_len <= 1'b1;
            end
            if (vs_rise && (state == CAPTURE) && (lines_with_partial != LINE_CNT_W'(EXP_LINES))) begin
                err_frame_len <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg    = ^{32'(EXP_BYTES_PER_LINE), 32'(EXP_LINES)};
    assign err_line_len  = 1'b0;
    assign err_frame_len = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Self-checking bench for dvp_capture_ctrl: randomized frames scored against a beat-queue model.
module tb_dvp_capture_ctrl;

    localparam int DATA_W     = 8;
    localparam int LINE_CNT_W = 11;
    localparam int BYTE_CNT_W = 12;

`ifdef DVP_CTRL_LINE_CHECK_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    logic                  pclk = 1'b0;
    logic                  rst;
    logic                  vsync;
    logic [DATA_W-1:0]     s_tdata;
    logic                  s_tlast;
    logic                  s_tvalid;
    logic [DATA_W-1:0]     m_tdata;
    logic                  m_tlast;
    logic                  m_tuser;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  start;
    logic                  stop;
    logic                  continuous;
    logic [3:0]            frame_skip;
    logic                  busy;
    logic                  frame_done;
    logic [LINE_CNT_W-1:0] frame_lines;
    logic [BYTE_CNT_W-1:0] line_bytes;
    logic                  overflow;
    logic                  err_line_len;
    logic                  err_frame_len;

    int vectors     = 0;
    int miscompares = 0;
    int done_count  = 0;

    // Expected forwarded beats, packed as {user, last, data}.
    logic [DATA_W+1:0] exp_q [$];
    logic [DATA_W+1:0] mon_exp;
    bit                cap_now       = 1'b0;
    bit                first_pending = 1'b0;

    always #5 pclk = ~pclk;

    dvp_capture_ctrl #(
        .DATA_W             (DATA_W),
        .LINE_CNT_W         (LINE_CNT_W),
        .BYTE_CNT_W         (BYTE_CNT_W),
        .EXP_BYTES_PER_LINE (10),
        .EXP_LINES          (2)
    ) dut (
        .pclk          (pclk),
        .rst           (rst),
        .vsync         (vsync),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .s_tvalid      (s_tvalid),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .start         (start),
        .stop          (stop),
        .continuous    (continuous),
        .frame_skip    (frame_skip),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_lines   (frame_lines),
        .line_bytes    (line_bytes),
        .overflow      (overflow),
        .err_line_len  (err_line_len),
        .err_frame_len (err_frame_len)
    );

    // Monitor samples 3 ns after the falling edge; a valid&&ready seen here completes at the next rising edge.
    always begin
        @(negedge pclk);
        #3;
        if (rst !== 1'b1) begin
            if (frame_done === 1'b1) done_count++;
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL beat_unexpected got user=%b last=%b data=%h, required no beat",
                             m_tuser, m_tlast, m_tdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({m_tuser, m_tlast, m_tdata} !== mon_exp) begin
                        miscompares++;
                        $display("[TB] FAIL beat got user=%b last=%b data=%h, required user=%b last=%b data=%h",
                                 m_tuser, m_tlast, m_tdata, mon_exp[DATA_W+1], mon_exp[DATA_W], mon_exp[DATA_W-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog got timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            start    = 1'b0;
            stop     = 1'b0;
        end
    endtask

    task automatic send_byte(input bit last, input bit do_stop);
        @(negedge pclk);
        s_tvalid = 1'b1;
        s_tdata  = DATA_W'($urandom);
        s_tlast  = last;
        stop     = do_stop;
        start    = 1'b0;
        if (cap_now) begin
            exp_q.push_back({first_pending, last, s_tdata});
            first_pending = 1'b0;
        end
    endtask

    task automatic send_line(input int n, input int stop_at);
        for (int i = 0; i < n; i++) begin
            send_byte(i == n - 1, i == stop_at);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
    endtask

    task automatic pulse_start(input bit cont, input logic [3:0] skip);
        @(negedge pclk);
        start      = 1'b1;
        continuous = cont;
        frame_skip = skip;
        idle(2);
    endtask

    task automatic pulse_stop();
        @(negedge pclk);
        stop = 1'b1;
        idle(2);
    endtask

    task automatic frame_open(input bit cap);
        @(negedge pclk);
        vsync    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        idle(5);
        cap_now       = cap;
        first_pending = cap;
    endtask

    task automatic frame_close();
        idle(2);
        vsync = 1'b1;
        idle(6);
        cap_now = 1'b0;
    endtask

    task automatic test_reset();
        idle(1);
        #3;
        vectors++;
        if ({m_tvalid, m_tlast, m_tuser, busy, frame_done, overflow, err_line_len, err_frame_len} !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got %b, required 00000000",
                     {m_tvalid, m_tlast, m_tuser, busy, frame_done, overflow, err_line_len, err_frame_len});
        end
        vectors++;
        if ({m_tdata, frame_lines, line_bytes} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_values got data=%h lines=%0d bytes=%0d, required all 0",
                     m_tdata, frame_lines, line_bytes);
        end
    endtask

    task automatic test_single_shot();
        done_count = 0;
        pulse_start(1'b0, 4'd0);
        #3;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_busy_armed got %b, required 1", busy);
        end
        frame_open(1'b1);
        send_line(10, -1);
        send_line(10, -1);
        frame_close();
        #3;
        vectors++;
        if (done_count !== 1) begin
            miscompares++;
            $display("[TB] FAIL single_frame_done got %0d pulses, required 1", done_count);
        end
        vectors++;
        if (frame_lines !== LINE_CNT_W'(2)) begin
            miscompares++;
            $display("[TB] FAIL single_frame_lines got %0d, required 2", frame_lines);
        end
        vectors++;
        if (line_bytes !== BYTE_CNT_W'(10)) begin
            miscompares++;
            $display("[TB] FAIL single_line_bytes got %0d, required 10", line_bytes);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_busy_end got %b, required 0", busy);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL single_missing got %0d beats outstanding, required 0", exp_q.size());
        end
        // A frame arriving after a single shot must not be forwarded.
        frame_open(1'b0);
        send_line(10, -1);
        frame_close();
        #3;
        vectors++;
        if (done_count !== 1) begin
            miscompares++;
            $display("[TB] FAIL idle_frame_done got %0d pulses, required 1", done_count);
        end
    endtask

    task automatic test_frame_skip();
        int last_lines;
        int nlines;
        int ncap;
        bit cap;
        done_count = 0;
        last_lines = 0;
        ncap       = 0;
        pulse_start(1'b1, 4'd2);
        for (int f = 0; f < 6; f++) begin
            cap    = ((f % 3) == 0);
            nlines = $urandom_range(1, 3);
            frame_open(cap);
            for (int l = 0; l < nlines; l++) send_line($urandom_range(4, 12), -1);
            frame_close();
            if (cap) begin
                last_lines = nlines;
                ncap++;
            end
        end
        #3;
        vectors++;
        if (done_count !== ncap) begin
            miscompares++;
            $display("[TB] FAIL skip_frame_done got %0d, required %0d", done_count, ncap);
        end
        vectors++;
        if (frame_lines !== LINE_CNT_W'(last_lines)) begin
            miscompares++;
            $display("[TB] FAIL skip_frame_lines got %0d, required %0d", frame_lines, last_lines);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL skip_busy_cont got %b, required 1", busy);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL skip_missing got %0d beats outstanding, required 0", exp_q.size());
        end
        pulse_stop();
        #3;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL skip_stop_in_arm got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] b [10];
        for (int i = 0; i < 10; i++) b[i] = DATA_W'($urandom);
        done_count = 0;
        pulse_start(1'b0, 4'd0);
        frame_open(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                @(negedge pclk);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                m_tready = 1'b0;
            end
            @(negedge pclk);
            s_tvalid = 1'b1;
            s_tdata  = b[i];
            s_tlast  = (i == 9);
            m_tready = !(i == 4 || i == 5);
            if (!(i == 4 || i == 5)) begin
                exp_q.push_back({first_pending, (i == 9), b[i]});
                first_pending = 1'b0;
            end
            if (i >= 4 && i <= 6) begin
                #3;
                vectors++;
                if (m_tvalid !== 1'b1 || m_tdata !== b[3]) begin
                    miscompares++;
                    $display("[TB] FAIL ovf_held got valid=%b data=%h, required valid=1 data=%h",
                             m_tvalid, m_tdata, b[3]);
                end
            end
        end
        idle(1);
        frame_close();
        #3;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_sticky got %b, required 1", overflow);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL ovf_missing got %0d beats outstanding, required 0", exp_q.size());
        end
        vectors++;
        if (done_count !== 1) begin
            miscompares++;
            $display("[TB] FAIL ovf_frame_done got %0d, required 1", done_count);
        end
        pulse_start(1'b0, 4'd0);
        #3;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_clear_on_start got %b, required 0", overflow);
        end
        pulse_stop();
    endtask

    task automatic test_line_check();
        pulse_start(1'b0, 4'd0);
        frame_open(1'b1);
        send_line(9, -1);
        #3;
        vectors++;
        if (line_bytes !== BYTE_CNT_W'(9)) begin
            miscompares++;
            $display("[TB] FAIL lc_short_bytes got %0d, required 9", line_bytes);
        end
        vectors++;
        if (err_line_len !== LC) begin
            miscompares++;
            $display("[TB] FAIL lc_line_err got %b, required %b", err_line_len, LC);
        end
        send_line(10, -1);
        frame_close();
        #3;
        vectors++;
        if (err_frame_len !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lc_frame_ok got %b, required 0", err_frame_len);
        end
        pulse_start(1'b0, 4'd0);
        #3;
        vectors++;
        if (err_line_len !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lc_clear_on_start got %b, required 0", err_line_len);
        end
        frame_open(1'b1);
        for (int l = 0; l < 3; l++) send_line(10, -1);
        frame_close();
        #3;
        vectors++;
        if (err_frame_len !== LC || err_line_len !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lc_long_frame got frame_err=%b line_err=%b, required %b and 0",
                     err_frame_len, err_line_len, LC);
        end
        vectors++;
        if (frame_lines !== LINE_CNT_W'(3)) begin
            miscompares++;
            $display("[TB] FAIL lc_frame_lines got %0d, required 3", frame_lines);
        end
    endtask

    task automatic test_stop();
        done_count = 0;
        pulse_start(1'b1, 4'd0);
        frame_open(1'b1);
        send_line(10, 4);
        send_line(10, -1);
        frame_close();
        #3;
        vectors++;
        if (done_count !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stop_finish got done=%0d busy=%b, required 1 and 0", done_count, busy);
        end
        frame_open(1'b0);
        send_line(10, -1);
        frame_close();
        #3;
        vectors++;
        if (done_count !== 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL stop_after got done=%0d outstanding=%0d, required 1 and 0",
                     done_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        pulse_start(1'b0, 4'd0);
        frame_open(1'b0);
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(1'b0, 1'b0);
        idle(1);
        #3;
        vectors++;
        if (m_tvalid !== 1'b1 || overflow !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rstmid_pre got valid=%b ovf=%b busy=%b, required 1 1 1",
                     m_tvalid, overflow, busy);
        end
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst      = 1'b0;
        m_tready = 1'b1;
        #3;
        vectors++;
        if ({m_tvalid, busy, overflow, frame_done, m_tuser, m_tlast} !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_flags got valid=%b busy=%b ovf=%b done=%b user=%b last=%b, required all 0",
                     m_tvalid, busy, overflow, frame_done, m_tuser, m_tlast);
        end
        vectors++;
        if (frame_lines !== '0 || line_bytes !== '0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_counters got lines=%0d bytes=%0d, required 0 0", frame_lines, line_bytes);
        end
        vsync = 1'b1;
        idle(6);
    endtask

    initial begin
        rst        = 1'b1;
        vsync      = 1'b1;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        frame_skip = 4'd0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;

        test_reset();
        test_single_shot();
        test_frame_skip();
        test_overflow();
        test_line_check();
        test_stop();
        test_reset_mid_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
